// File: rtl/dna_loader.sv
// ----------------------------------------------------------------------------
// dna_loader
//
// Writer side of the nucleotide sequence memory. Accepts an ASCII nucleotide
// stream over a valid/ready handshake, encodes each letter to a 2-bit code
// (A=00, C=01, G=10, T=11, upper or lower case) and writes the codes to
// consecutive addresses starting at dna_start. When the load ends it reports
// the number of nucleotides written on dna_length.
//
// A load ends in one of three ways:
//   - the terminator character TERM is accepted   -> DONE, nothing written
//   - max_length nucleotides have been written    -> DONE, no terminator needed
//   - any other character is accepted             -> ERR, nothing written
//
// Ports
//   clock       system clock, rising edge
//   reset_N     asynchronous active-low reset
//   start       one-cycle load request, honoured in IDLE, DONE or ERR
//   dna_start   base address, sampled on an accepted start
//   max_length  capacity in nucleotides, sampled on an accepted start
//   in_valid    in_char holds a character
//   in_char     ASCII character
//   in_ready    loader accepts a character this cycle (high only in RUN)
//   mem_we      one-cycle write strobe, one cycle after a nucleotide accept
//   mem_addr    write address
//   mem_data    encoded nucleotide
//   done        load finished, held until the next accepted start
//   error       load aborted, held until the next accepted start
//   dna_length  nucleotides written, valid while done or error is high
// ----------------------------------------------------------------------------
module dna_loader #(
    parameter int          AW   = 16,
    parameter logic [7:0]  TERM = 8'h2E
) (
    input  logic          clock,
    input  logic          reset_N,
    input  logic          start,
    input  logic [AW-1:0] dna_start,
    input  logic [AW-1:0] max_length,
    input  logic          in_valid,
    input  logic [7:0]    in_char,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [1:0]    mem_data,
    output logic          done,
    output logic          error,
    output logic [AW-1:0] dna_length
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t        state_q,      state_d;
    logic [AW-1:0] addr_ptr_q,   addr_ptr_d;
    logic [AW-1:0] count_q,      count_d;
    logic [AW-1:0] max_len_q,    max_len_d;
    logic          done_q,       done_d;
    logic          error_q,      error_d;
    logic [AW-1:0] dna_length_q, dna_length_d;
    logic          mem_we_q,     mem_we_d;
    logic [AW-1:0] mem_addr_q,   mem_addr_d;
    logic [1:0]    mem_data_q,   mem_data_d;
    logic          in_ready_q,   in_ready_d;

    logic          accept;
    logic          is_nuc;
    logic [1:0]    nuc_code;
    logic [AW-1:0] count_inc;

    // Letter classification: is_nuc flags the eight legal letters, nuc_code
    // is their 2-bit encoding (case-insensitive).
    always_comb begin
        is_nuc   = 1'b1;
        nuc_code = 2'b00;
        case (in_char)
            8'h41, 8'h61: nuc_code = 2'b00;  // A a
            8'h43, 8'h63: nuc_code = 2'b01;  // C c
            8'h47, 8'h67: nuc_code = 2'b10;  // G g
            8'h54, 8'h74: nuc_code = 2'b11;  // T t
            default: begin
                is_nuc   = 1'b0;
                nuc_code = 2'b00;
            end
        endcase
    end

    assign accept    = in_valid && in_ready_q;
    assign count_inc = count_q + ONE;

    always_comb begin
        state_d      = state_q;
        addr_ptr_d   = addr_ptr_q;
        count_d      = count_q;
        max_len_d    = max_len_q;
        done_d       = done_q;
        error_d      = error_q;
        dna_length_d = dna_length_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;

        case (state_q)
            S_RUN: begin
                // start is deliberately ignored here; only characters matter.
                if (accept) begin
                    if (is_nuc) begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = addr_ptr_q;
                        mem_data_d = nuc_code;
                        addr_ptr_d = addr_ptr_q + ONE;  // wraps silently
                        count_d    = count_inc;
                        // Capacity reached: finish on the same edge so the
                        // next character is never offered in_ready.
                        if (count_inc == max_len_q) begin
                            state_d      = S_DONE;
                            done_d       = 1'b1;
                            dna_length_d = count_inc;
                        end
                    end else if (in_char == TERM) begin
                        state_d      = S_DONE;
                        done_d       = 1'b1;
                        dna_length_d = count_q;
                    end else begin
                        // Already written words stay in memory.
                        state_d      = S_ERR;
                        error_d      = 1'b1;
                        dna_length_d = count_q;
                    end
                end
            end
            default: begin  // S_IDLE, S_DONE, S_ERR
                if (start) begin
                    addr_ptr_d   = dna_start;
                    count_d      = '0;
                    max_len_d    = max_length;
                    error_d      = 1'b0;
                    dna_length_d = '0;
                    if (max_length == '0) begin
                        // Zero capacity: complete immediately, empty sequence.
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        done_d  = 1'b0;
                    end
                end
            end
        endcase

        // in_ready is registered from the next state so it is glitch-free and
        // drops in the very cycle after the final accept.
        in_ready_d = (state_d == S_RUN);
    end

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            state_q      <= S_IDLE;
            addr_ptr_q   <= '0;
            count_q      <= '0;
            max_len_q    <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            dna_length_q <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            in_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_ptr_q   <= addr_ptr_d;
            count_q      <= count_d;
            max_len_q    <= max_len_d;
            done_q       <= done_d;
            error_q      <= error_d;
            dna_length_q <= dna_length_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign done       = done_q;
    assign error      = error_q;
    assign dna_length = dna_length_q;

endmodule

// File: tb/tb_dna_loader.sv
// ----------------------------------------------------------------------------
// tb_dna_loader
//
// Directed scenarios plus randomized loads for dna_loader. Writes are logged
// by a monitor together with the cycle they appear in; the driver logs the
// cycle of every accepted character so write latency can be checked.
// ----------------------------------------------------------------------------
module tb_dna_loader;

    logic        clock = 1'b0;
    logic        reset_N = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dna_start = '0;
    logic [15:0] max_length = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_char = '0;
    logic        in_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [1:0]  mem_data;
    logic        done;
    logic        error;
    logic [15:0] dna_length;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc_cnt = 0;

    logic [15:0] w_addr[$];
    logic [1:0]  w_data[$];
    int          w_cyc[$];
    int          acc_cyc[$];

    // reference model results
    logic [15:0] exp_addr[$];
    logic [1:0]  exp_data[$];
    int          exp_consumed;
    bit          exp_done;
    bit          exp_err;
    int          exp_len;

    dna_loader #(.AW(16), .TERM(8'h2E)) dut (
        .clock      (clock),
        .reset_N    (reset_N),
        .start      (start),
        .dna_start  (dna_start),
        .max_length (max_length),
        .in_valid   (in_valid),
        .in_char    (in_char),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .done       (done),
        .error      (error),
        .dna_length (dna_length)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clock) begin
        if (mem_we) begin
            w_addr.push_back(mem_addr);
            w_data.push_back(mem_data);
            w_cyc.push_back(cyc_cnt);
        end
    end

    task automatic clear_log();
        w_addr.delete();
        w_data.delete();
        w_cyc.delete();
        acc_cyc.delete();
    endtask

    // Called at a negedge; returns at a negedge with start low.
    task automatic pulse_start(input logic [15:0] base, input logic [15:0] maxl);
        start      = 1'b1;
        dna_start  = base;
        max_length = maxl;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Offers characters of s until the loader stops being ready or the
    // string runs out. in_ready is registered, so its negedge value tells
    // whether the character presented now is taken at the next rising edge.
    task automatic stream(input string s, input bit stall);
        int  i = 0;
        bit  gap = 1'b0;
        bit  ended = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (!in_ready || i >= s.len()) begin
                in_valid = 1'b0;
                ended = 1'b1;
                break;
            end
            if (stall && gap) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_char  = s[i];
                acc_cyc.push_back(cyc_cnt + 1);
                i++;
            end
            gap = stall ? !gap : 1'b0;
            @(negedge clock);
        end
        in_valid = 1'b0;
        if (!ended) begin
            tests_run++;
            tests_failed++;
            $display("FAIL stream_timeout: loader still ready after 300 cycles, required to stop");
        end
    endtask

    // Behavioural model: walks the character list applying the load rules.
    task automatic model(input logic [15:0] base, input logic [15:0] maxl, input string s);
        int n = 0;
        exp_addr.delete();
        exp_data.delete();
        exp_consumed = 0;
        exp_done = 1'b0;
        exp_err = 1'b0;
        exp_len = 0;
        if (maxl == 16'd0) begin
            exp_done = 1'b1;
            return;
        end
        for (int k = 0; k < s.len(); k++) begin
            byte c = s[k];
            int  code;
            exp_consumed++;
            case (c)
                8'h41, 8'h61: code = 0;
                8'h43, 8'h63: code = 1;
                8'h47, 8'h67: code = 2;
                8'h54, 8'h74: code = 3;
                default:      code = -1;
            endcase
            if (code < 0) begin
                if (c == 8'h2E) exp_done = 1'b1;
                else            exp_err  = 1'b1;
                exp_len = n;
                return;
            end
            exp_addr.push_back(base + 16'(n));
            exp_data.push_back(2'(code));
            n++;
            if (n == int'(maxl)) begin
                exp_done = 1'b1;
                exp_len = n;
                return;
            end
        end
        exp_len = n;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        tests_run++;
        if ({in_ready, mem_we, done, error} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b, required 0000", {in_ready, mem_we, done, error});
        end
        tests_run++;
        if ({mem_addr, mem_data, dna_length} !== 34'd0) begin
            tests_failed++;
            $display("FAIL reset_buses: addr=%h data=%h len=%h, required all 0", mem_addr, mem_data, dna_length);
        end
        reset_N = 1'b1;
        repeat (2) @(negedge clock);
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_not_ready: in_ready=%b, required 0", in_ready);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_basic();
        clear_log();
        pulse_start(16'h0010, 16'd100);
        stream("ACGT.", 1'b0);
        @(negedge clock);
        tests_run++;
        if (w_addr.size() !== 4) begin
            tests_failed++;
            $display("FAIL basic_nwrites: got %0d, required 4", w_addr.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                tests_run++;
                if (w_addr[j] !== 16'h0010 + 16'(j) || w_data[j] !== 2'(j) || w_cyc[j] !== acc_cyc[j]) begin
                    tests_failed++;
                    $display("FAIL basic_write%0d: got (%h,%b)@%0d, required (%h,%b)@%0d",
                             j, w_addr[j], w_data[j], w_cyc[j], 16'h0010 + 16'(j), 2'(j), acc_cyc[j]);
                end
            end
        end
        tests_run++;
        if (done !== 1'b1 || error !== 1'b0 || dna_length !== 16'd4) begin
            tests_failed++;
            $display("FAIL basic_status: done=%b error=%b len=%0d, required 1 0 4", done, error, dna_length);
        end
        $display("[TB] basic load: %0d writes, len=%0d", w_addr.size(), dna_length);
    endtask

    task automatic test_capacity();
        logic [1:0] req [3] = '{2'b10, 2'b00, 2'b11};
        clear_log();
        pulse_start(16'h0200, 16'd3);
        stream("gattaca", 1'b0);
        tests_run++;
        if (in_ready !== 1'b0 || acc_cyc.size() !== 3) begin
            tests_failed++;
            $display("FAIL cap_ready_drop: in_ready=%b consumed=%0d, required 0 and 3", in_ready, acc_cyc.size());
        end
        @(negedge clock);
        tests_run++;
        if (w_addr.size() !== 3) begin
            tests_failed++;
            $display("FAIL cap_nwrites: got %0d, required 3", w_addr.size());
        end else begin
            for (int j = 0; j < 3; j++) begin
                tests_run++;
                if (w_addr[j] !== 16'h0200 + 16'(j) || w_data[j] !== req[j]) begin
                    tests_failed++;
                    $display("FAIL cap_write%0d: got (%h,%b), required (%h,%b)",
                             j, w_addr[j], w_data[j], 16'h0200 + 16'(j), req[j]);
                end
            end
        end
        tests_run++;
        if (done !== 1'b1 || error !== 1'b0 || dna_length !== 16'd3) begin
            tests_failed++;
            $display("FAIL cap_status: done=%b error=%b len=%0d, required 1 0 3", done, error, dna_length);
        end
        $display("[TB] capacity stop: %0d writes, len=%0d", w_addr.size(), dna_length);
    endtask

    task automatic test_illegal();
        clear_log();
        pulse_start(16'h0300, 16'd50);
        stream("ACX", 1'b0);
        repeat (2) @(negedge clock);
        tests_run++;
        if (w_addr.size() !== 2) begin
            tests_failed++;
            $display("FAIL illegal_nwrites: got %0d, required 2", w_addr.size());
        end
        tests_run++;
        if (error !== 1'b1 || done !== 1'b0 || dna_length !== 16'd2) begin
            tests_failed++;
            $display("FAIL illegal_status: error=%b done=%b len=%0d, required 1 0 2", error, done, dna_length);
        end
        $display("[TB] illegal char: %0d writes, error=%b", w_addr.size(), error);
    endtask

    task automatic test_wrap_stall();
        logic [15:0] req [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
        clear_log();
        pulse_start(16'hFFFE, 16'd20);
        stream("TTT.", 1'b1);
        repeat (2) @(negedge clock);
        tests_run++;
        if (w_addr.size() !== 3) begin
            tests_failed++;
            $display("FAIL wrap_nwrites: got %0d, required 3", w_addr.size());
        end else begin
            for (int j = 0; j < 3; j++) begin
                tests_run++;
                if (w_addr[j] !== req[j] || w_data[j] !== 2'b11 || w_cyc[j] !== acc_cyc[j]) begin
                    tests_failed++;
                    $display("FAIL wrap_write%0d: got (%h,%b)@%0d, required (%h,11)@%0d",
                             j, w_addr[j], w_data[j], w_cyc[j], req[j], acc_cyc[j]);
                end
            end
        end
        tests_run++;
        if (done !== 1'b1 || dna_length !== 16'd3) begin
            tests_failed++;
            $display("FAIL wrap_status: done=%b len=%0d, required 1 3", done, dna_length);
        end
        $display("[TB] wrap with stalls: %0d writes, len=%0d", w_addr.size(), dna_length);
    endtask

    task automatic test_zero_max();
        clear_log();
        pulse_start(16'h0040, 16'd0);
        tests_run++;
        if (done !== 1'b1 || error !== 1'b0 || dna_length !== 16'd0 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_max_status: done=%b error=%b len=%0d rdy=%b, required 1 0 0 0",
                     done, error, dna_length, in_ready);
        end
        in_valid = 1'b1;
        in_char  = 8'h41;
        repeat (3) @(negedge clock);
        in_valid = 1'b0;
        tests_run++;
        if (w_addr.size() !== 0) begin
            tests_failed++;
            $display("FAIL zero_max_writes: got %0d, required 0", w_addr.size());
        end
        $display("[TB] zero capacity: done=%b len=%0d", done, dna_length);
    endtask

    task automatic test_start_in_run();
        clear_log();
        pulse_start(16'h0100, 16'd10);
        stream("AC", 1'b0);
        pulse_start(16'h0500, 16'd1);
        stream("G.", 1'b0);
        @(negedge clock);
        tests_run++;
        if (w_addr.size() !== 3 || (w_addr.size() == 3 && w_addr[2] !== 16'h0102)) begin
            tests_failed++;
            $display("FAIL start_in_run_writes: n=%0d last=%h, required 3 writes ending at 0102",
                     w_addr.size(), (w_addr.size() > 0) ? w_addr[w_addr.size()-1] : 16'hxxxx);
        end
        tests_run++;
        if (done !== 1'b1 || dna_length !== 16'd3) begin
            tests_failed++;
            $display("FAIL start_in_run_len: done=%b len=%0d, required 1 3", done, dna_length);
        end
        $display("[TB] start during run ignored: len=%0d", dna_length);
    endtask

    task automatic test_restart();
        clear_log();
        pulse_start(16'h2000, 16'd5);
        tests_run++;
        if (done !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL restart_clear: done=%b rdy=%b, required 0 1", done, in_ready);
        end
        stream("TG.", 1'b0);
        @(negedge clock);
        tests_run++;
        if (w_addr.size() !== 2 || (w_addr.size() == 2 && (w_addr[0] !== 16'h2000 || w_addr[1] !== 16'h2001))) begin
            tests_failed++;
            $display("FAIL restart_base: n=%0d first=%h, required 2 writes at 2000,2001",
                     w_addr.size(), (w_addr.size() > 0) ? w_addr[0] : 16'hxxxx);
        end
        $display("[TB] restart from done: %0d writes, len=%0d", w_addr.size(), dna_length);
    endtask

    task automatic test_reset_midload();
        clear_log();
        pulse_start(16'h0080, 16'd10);
        in_valid = 1'b1;
        in_char  = 8'h41;
        @(negedge clock);
        in_char  = 8'h43;
        @(posedge clock);
        #1 reset_N = 1'b0;
        #1;
        tests_run++;
        if ({in_ready, mem_we, done, error} !== 4'b0000 || {mem_addr, mem_data, dna_length} !== 34'd0) begin
            tests_failed++;
            $display("FAIL midload_async: rdy=%b we=%b done=%b err=%b addr=%h data=%b len=%h, required all 0",
                     in_ready, mem_we, done, error, mem_addr, mem_data, dna_length);
        end
        in_char = 8'h47;
        @(negedge clock);
        reset_N = 1'b1;
        repeat (4) @(negedge clock);
        in_valid = 1'b0;
        tests_run++;
        if (w_addr.size() !== 1 || in_ready !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL midload_after: writes=%0d rdy=%b done=%b, required 1 0 0",
                     w_addr.size(), in_ready, done);
        end
        $display("[TB] reset mid-load: writes=%0d", w_addr.size());
    endtask

    task automatic test_random();
        string pool = "ACGTacgt";
        string bad  = "XNu-";
        for (int t = 0; t < 25; t++) begin
            string s = "";
            string cs = " ";
            logic [15:0] base = 16'($urandom);
            logic [15:0] maxl = ($urandom_range(0, 99) < 12) ? 16'd0 : 16'($urandom_range(1, 25));
            bit stall = 1'($urandom_range(0, 1));
            int L = $urandom_range(1, 20);
            for (int k = 0; k < L; k++) begin
                int r = $urandom_range(0, 99);
                if (r < 92)      cs[0] = pool[$urandom_range(0, 7)];
                else if (r < 96) cs[0] = 8'h2E;
                else             cs[0] = bad[$urandom_range(0, 3)];
                s = {s, cs};
            end
            s = {s, "."};
            model(base, maxl, s);
            clear_log();
            pulse_start(base, maxl);
            stream(s, stall);
            @(negedge clock);
            tests_run++;
            if (w_addr.size() !== exp_addr.size() || acc_cyc.size() !== exp_consumed) begin
                tests_failed++;
                $display("FAIL rand%0d_counts: writes=%0d consumed=%0d, required %0d %0d",
                         t, w_addr.size(), acc_cyc.size(), exp_addr.size(), exp_consumed);
            end else begin
                for (int j = 0; j < exp_addr.size(); j++) begin
                    tests_run++;
                    if (w_addr[j] !== exp_addr[j] || w_data[j] !== exp_data[j] || w_cyc[j] !== acc_cyc[j]) begin
                        tests_failed++;
                        $display("FAIL rand%0d_write%0d: got (%h,%b)@%0d, required (%h,%b)@%0d",
                                 t, j, w_addr[j], w_data[j], w_cyc[j], exp_addr[j], exp_data[j], acc_cyc[j]);
                    end
                end
            end
            tests_run++;
            if (done !== exp_done || error !== exp_err || dna_length !== 16'(exp_len) || in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL rand%0d_status: done=%b err=%b len=%0d rdy=%b, required %b %b %0d 0",
                         t, done, error, dna_length, in_ready, exp_done, exp_err, exp_len);
            end
            $display("[TB] random load %0d: base=%h max=%0d stall=%0d str=%s len=%0d",
                     t, base, maxl, stall, s, dna_length);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_max();
        test_capacity();
        test_illegal();
        test_wrap_stall();
        test_start_in_run();
        test_restart();
        test_random();
        test_reset_midload();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
